// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared states, default timing constants and helpers for the push-button conditioner
package btn_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    REPEAT,
    RELEASE_WAIT
  } btn_state_e;

  // Default cycle counts for a 100 MHz clock.
  localparam int DEB_10MS   = 1_000_000;
  localparam int HOLD_500MS = 50_000_000;
  localparam int REP_100MS  = 10_000_000;

  // Largest of three timing values; sizes the shared per-channel counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/btn_channel.sv
// rtl/btn_channel.sv - one button: 2-flop synchronizer, debounce/hold/repeat counter and FSM
module btn_channel
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEB_10MS,
  parameter int HOLD_CYCLES     = HOLD_500MS,
  parameter int REPEAT_CYCLES   = REP_100MS,
  parameter int REPEAT_EN       = 1
) (
  input  logic clk,
  input  logic btnC,
  input  logic raw,
  output logic pulse,
  output logic level
);

  // One counter serves every timed state, so it is sized for the longest interval.
  localparam int CNT_W = $clog2(max3(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES));

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic [1:0]       sync_q;
  logic             s;
  btn_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;
  logic             level_q, level_d;

  assign s     = sync_q[1];
  assign pulse = pulse_q;
  assign level = level_q;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clk) begin
    if (btnC) sync_q <= 2'b00;
    else      sync_q <= {sync_q[0], raw};
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (btnC) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      level_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      level_q <= level_d;
    end
  end

  // Next-state logic; the counter restarts on every state change.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    level_d = level_q;
    unique case (state_q)
      IDLE: begin
        level_d = 1'b0;
        if (s) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = PRESSED;
          cnt_d   = '0;
          level_d = 1'b1;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (!s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end else if ((REPEAT_EN != 0) && (cnt_q == HOLD_LAST)) begin
          state_d = REPEAT;
          cnt_d   = '0;
          pulse_d = 1'b1;
        end else if (cnt_q != CNT_MAX) begin
          // Saturates during an indefinite hold when repeat is disabled.
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      REPEAT: begin
        if (!s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end else if (cnt_q == REP_LAST) begin
          cnt_d   = '0;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RELEASE_WAIT: begin
        level_d = 1'b1;
        if (s) begin
          // Release bounce: resume holding with a fresh hold interval.
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          level_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/pushbutton_conditioner.sv
// rtl/pushbutton_conditioner.sv - two independent debounced, auto-repeating button channels
module pushbutton_conditioner
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEB_10MS,
  parameter int HOLD_CYCLES     = HOLD_500MS,
  parameter int REPEAT_CYCLES   = REP_100MS,
  parameter int REPEAT_EN       = 1
) (
  input  logic clk,
  input  logic btnC,
  input  logic btnU,
  input  logic btnR,
  output logic up_pulse,
  output logic ten_pulse,
  output logic up_level,
  output logic ten_level
);

  btn_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .HOLD_CYCLES    (HOLD_CYCLES),
    .REPEAT_CYCLES  (REPEAT_CYCLES),
    .REPEAT_EN      (REPEAT_EN)
  ) u_up (
    .clk  (clk),
    .btnC (btnC),
    .raw  (btnU),
    .pulse(up_pulse),
    .level(up_level)
  );

  btn_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .HOLD_CYCLES    (HOLD_CYCLES),
    .REPEAT_CYCLES  (REPEAT_CYCLES),
    .REPEAT_EN      (REPEAT_EN)
  ) u_ten (
    .clk  (clk),
    .btnC (btnC),
    .raw  (btnR),
    .pulse(ten_pulse),
    .level(ten_level)
  );

endmodule

// File: tb/tb_pushbutton_conditioner.sv
// tb/tb_pushbutton_conditioner.sv - directed and randomized checks of pushbutton_conditioner
module tb_pushbutton_conditioner;

  localparam int D = 4;
  localparam int H = 20;
  localparam int R = 8;

  logic clk = 1'b0;
  logic btnC, btnU, btnR;
  logic up_pulse, ten_pulse, up_level, ten_level;

  int checks   = 0;
  int failures = 0;

  // Reference model state, index 0 = btnU channel, 1 = btnR channel.
  logic m1 [2];
  logic m2 [2];
  logic lvl [2];
  logic prev_s [2];
  int   run_c [2];
  int   k_c [2];
  logic exp_pulse [2];

  pushbutton_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES    (H),
    .REPEAT_CYCLES  (R),
    .REPEAT_EN      (1)
  ) dut (
    .clk      (clk),
    .btnC     (btnC),
    .btnU     (btnU),
    .btnR     (btnR),
    .up_pulse (up_pulse),
    .ten_pulse(ten_pulse),
    .up_level (up_level),
    .ten_level(ten_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Behaviour per clock edge: the synchronized value must disagree with the
  // debounced level for D+1 consecutive samples to flip it; while held, a pulse
  // fires H samples after the press (or after a release bounce) and every R after.
  task automatic model_edge(input logic rst, input logic raw_u, input logic raw_r);
    logic raw, s;
    for (int ch = 0; ch < 2; ch++) begin
      raw = (ch == 0) ? raw_u : raw_r;
      exp_pulse[ch] = 1'b0;
      if (rst) begin
        m1[ch] = 0; m2[ch] = 0; lvl[ch] = 0; prev_s[ch] = 0;
        run_c[ch] = 0; k_c[ch] = 0;
      end else begin
        s = m2[ch];
        if (s != lvl[ch]) begin
          run_c[ch]++;
          if (run_c[ch] == D + 1) begin
            lvl[ch] = s;
            run_c[ch] = 0;
            if (s) begin
              exp_pulse[ch] = 1'b1;
              k_c[ch] = 0;
            end
          end
        end else begin
          run_c[ch] = 0;
          if (s) begin
            if (prev_s[ch]) begin
              k_c[ch]++;
              if (k_c[ch] == H || (k_c[ch] > H && (k_c[ch] - H) % R == 0))
                exp_pulse[ch] = 1'b1;
            end else begin
              k_c[ch] = 0;
            end
          end
        end
        prev_s[ch] = s;
        m2[ch] = m1[ch];
        m1[ch] = raw;
      end
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge(btnC, btnU, btnR);
    #1;
    chk({tag, ":up_pulse"},  up_pulse,  exp_pulse[0]);
    chk({tag, ":ten_pulse"}, ten_pulse, exp_pulse[1]);
    chk({tag, ":up_level"},  up_level,  lvl[0]);
    chk({tag, ":ten_level"}, ten_level, lvl[1]);
  endtask

  task automatic settle(input string tag);
    btnU = 1'b0;
    btnR = 1'b0;
    for (int i = 0; i < 12; i++) step(tag);
  endtask

  initial begin
    int npulse;
    int mode;
    logic [7:0] bounce;

    btnC = 1'b1; btnU = 1'b0; btnR = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step("reset");
      chk("reset_outputs", {up_pulse, ten_pulse, up_level, ten_level}, 0);
    end
    btnC = 1'b0;
    for (int i = 0; i < 3; i++) step("idle");

    // 1. clean press and release
    btnU = 1'b1;
    for (int e = 0; e < 10; e++) begin
      step("s1_press");
      chk("s1_up_pulse_at6", up_pulse, e == 6);
      chk("s1_up_level", up_level, e >= 6);
      chk("s1_ten_pulse", ten_pulse, 0);
    end
    btnU = 1'b0;
    for (int e = 0; e < 10; e++) begin
      step("s1_release");
      chk("s1_release_level", up_level, e < 6);
    end

    // 2. bouncing btnR, then steady
    bounce = 8'b0011_0011;
    for (int i = 0; i < 8; i++) begin
      btnR = bounce[i];
      step("s2_bounce");
      chk("s2_no_pulse_in_bounce", ten_pulse, 0);
    end
    btnR = 1'b1;
    for (int f = 0; f < 12; f++) begin
      step("s2_hold");
      chk("s2_ten_pulse_at6", ten_pulse, f == 6);
    end
    settle("s2_settle");

    // 3. auto-repeat
    btnU = 1'b1;
    npulse = 0;
    for (int e = 0; e < 60; e++) begin
      step("s3_hold");
      if (up_pulse) npulse++;
      chk("s3_pulse_schedule", up_pulse, e inside {6, 26, 34, 42, 50, 58});
    end
    chk("s3_pulse_count", npulse, 6);
    settle("s3_settle");

    // 4. release bounce restarts the hold timer
    for (int e = 0; e < 40; e++) begin
      btnU = !(e == 12 || e == 13);
      step("s4_glitch");
      chk("s4_level_held", up_level, e >= 6);
      chk("s4_pulse_schedule", up_pulse, e == 6 || e == 36);
    end
    settle("s4_settle");

    // 5. simultaneous presses
    btnU = 1'b1; btnR = 1'b1;
    for (int e = 0; e < 10; e++) begin
      step("s5_both");
      chk("s5_up_pulse", up_pulse, e == 6);
      chk("s5_ten_pulse", ten_pulse, e == 6);
    end
    settle("s5_settle");

    // 6. reset during auto-repeat with the button still held
    btnU = 1'b1;
    for (int e = 0; e < 30; e++) step("s6_hold");
    btnC = 1'b1;
    step("s6_reset");
    chk("s6_outputs_cleared", {up_pulse, ten_pulse, up_level, ten_level}, 0);
    btnC = 1'b0;
    for (int e = 0; e < 10; e++) begin
      step("s6_repress");
      chk("s6_fresh_pulse", up_pulse, e == 6);
    end
    settle("s6_settle");

    // Randomized activity alternating between bouncy and long-hold regimes.
    mode = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) mode = $urandom_range(0, 2);
      case (mode)
        0:       begin if ($urandom_range(0, 2) == 0)  btnU = ~btnU; if ($urandom_range(0, 2) == 0)  btnR = ~btnR; end
        1:       begin if ($urandom_range(0, 9) == 0)  btnU = ~btnU; if ($urandom_range(0, 9) == 0)  btnR = ~btnR; end
        default: begin if ($urandom_range(0, 59) == 0) btnU = ~btnU; if ($urandom_range(0, 59) == 0) btnR = ~btnR; end
      endcase
      btnC = ($urandom_range(0, 299) == 0);
      step("rand");
    end
    btnC = 1'b0;
    settle("rand_settle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pushbutton_conditioner.md
Name: pushbutton_conditioner

Overview:
- Input-side counterpart to the 7-segment display/counter path. It turns raw, bouncy, asynchronous push-buttons (btnU, btnR) into clean single-cycle command pulses with hold-to-repeat.
- The display counter consumes up_pulse (+1) and ten_pulse (+10) directly. It no longer samples raw buttons on its 1 s enable.
- Two identical, independent channels share one clock and reset.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000: clocks the synchronized input must stay stable before a press or release is accepted (10 ms at 100 MHz). Must be ≥ 2.
- HOLD_CYCLES, 50_000_000: clocks held after the accepted press before the first auto-repeat pulse. Must be ≥ 2.
- REPEAT_CYCLES, 10_000_000: clocks between successive auto-repeat pulses. Must be ≥ 2.
- REPEAT_EN, 1: 1 enables auto-repeat; 0 gives exactly one pulse per press.

Ports:
- clk  in  1  system clock, 100 MHz
- btnC  in  1  reset; synchronous, active-high, sampled on the rising edge of clk
- btnU  in  1  raw button, asynchronous, active-high
- btnR  in  1  raw button, asynchronous, active-high
- up_pulse  out  1  one-clock pulse per accepted btnU press or repeat
- ten_pulse  out  1  one-clock pulse per accepted btnR press or repeat
- up_level  out  1  debounced btnU level
- ten_level  out  1  debounced btnR level

Behaviour:
- Reset: while btnC = 1 at a clk edge, all of the following clear to 0: both synchronizer flops, the counters, all outputs. Each FSM goes to IDLE. Reset overrides any in-progress debounce or repeat.
- Synchronizer: 2-flop chain per button. s denotes the second-flop output. No combinational path from a raw input to any output.
- Counter: one per channel, width $clog2(max(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES)). It clears on every state change and never wraps.
- Per-channel FSM transitions, evaluated at each clk edge:
  - IDLE: level = 0. If s = 1, go to PRESS_WAIT with cnt = 0.
  - PRESS_WAIT: if s = 0, return to IDLE with no pulse. Else if cnt == DEBOUNCE_CYCLES-1, go to PRESSED, set level = 1, assert pulse for one cycle. Else cnt++.
  - PRESSED: if s = 0, go to RELEASE_WAIT. Else if REPEAT_EN and cnt == HOLD_CYCLES-1, go to REPEAT with a pulse. Else cnt++ (saturating when REPEAT_EN = 0).
  - REPEAT: if s = 0, go to RELEASE_WAIT. Else if cnt == REPEAT_CYCLES-1, pulse, clear cnt, stay in REPEAT. Else cnt++.
  - RELEASE_WAIT: level stays 1. If s = 1 (a bounce), return to PRESSED with cnt = 0 and no pulse; the hold timer restarts. Else if cnt == DEBOUNCE_CYCLES-1, go to IDLE with level = 0. Else cnt++.
- Press latency, with edge 0 being the first edge sampling raw = 1 and raw held steady:
  - PRESS_WAIT is entered at edge 2.
  - Pulse is registered at edge DEBOUNCE_CYCLES+2 and is high for exactly one cycle.
  - level rises in the same cycle as the pulse.
- Release latency: level falls DEBOUNCE_CYCLES+2 edges after the first edge sampling raw = 0.
- Repeat timing:
  - First repeat pulse comes HOLD_CYCLES clocks after the press pulse.
  - Later repeat pulses come every REPEAT_CYCLES clocks.
- Pulses and levels are registered outputs. A pulse is never asserted on two consecutive cycles.
- Simultaneous presses: the channels are fully independent, so up_pulse and ten_pulse may assert in the same cycle. Arbitration belongs to the consumer.
- Reset while a button is held: after btnC deasserts, the channel starts from IDLE. The press is re-debounced and produces a fresh press pulse.
- A glitch shorter than DEBOUNCE_CYCLES produces no pulse and no level change.

Decomposition:
- Shared package btn_pkg holds:
  - the state enum (IDLE, PRESS_WAIT, PRESSED, REPEAT, RELEASE_WAIT);
  - default cycle constants for 100 MHz (DEB_10MS, HOLD_500MS, REP_100MS).
- Sub-module btn_channel contains the synchronizer, counter and FSM, with ports clk, btnC, raw, pulse, level. It is instantiated twice in pushbutton_conditioner.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=8, REPEAT_EN=1.
1. Clean press: btnU rises at edge 0 and is held 10 clocks, then released → up_pulse = 1 only in the cycle after edge 6. up_level rises at edge 6 and falls 6 edges after the first low sample. ten_pulse stays 0.
2. Bounce: btnR toggles 1,0,1,0 every 2 clocks, then holds high → no ten_pulse during the bounce. Exactly one ten_pulse occurs 6 edges after the final rise.
3. Auto-repeat: btnU held 60 clocks → press pulse at edge 6, repeats at edges 26, 34, 42, 50, 58. That is 6 pulses total, each 1 cycle wide.
4. Release bounce: btnU held, then a 2-clock low glitch → up_level stays 1, no extra pulse, and the hold timer restarts (next repeat 20 clocks after the glitch ends).
5. Simultaneous: btnU and btnR rise on the same edge → up_pulse and ten_pulse both high in the same single cycle.
6. Reset mid-hold: btnC pulsed for 1 clock during REPEAT with btnU still high → all outputs 0 the next cycle. A new press pulse follows 6 edges after reset release.
